// File: rtl/core_mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of the
// core memory arbiter. The arbiter connects through the slave modport; the
// surrounding core/memory (or a bench) uses the master modport.
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic                  IF_REQ;
  logic [ADDR_W-1:0]     IF_ADDR;
  logic                  IF_GNT;
  logic                  IF_RVALID;
  logic [DATA_W-1:0]     IF_RDATA;

  // Load/store requester
  logic                  D_REQ;
  logic                  D_WE;
  logic [DATA_W/8-1:0]   D_BE;
  logic [ADDR_W-1:0]     D_ADDR;
  logic [DATA_W-1:0]     D_WDATA;
  logic                  D_GNT;
  logic                  D_RVALID;
  logic [DATA_W-1:0]     D_RDATA;

  // Shared memory port
  logic                  MEM_REQ;
  logic                  MEM_WE;
  logic [DATA_W/8-1:0]   MEM_BE;
  logic [ADDR_W-1:0]     MEM_ADDR;
  logic [DATA_W-1:0]     MEM_WDATA;
  logic                  MEM_GNT;
  logic                  MEM_RVALID;
  logic [DATA_W-1:0]     MEM_RDATA;

  // Status
  logic                  BUS_ERR;
  logic                  BUSY;

  modport slave (
    input  IF_REQ, IF_ADDR,
    input  D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA,
    output IF_GNT, IF_RVALID, IF_RDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA,
    output BUS_ERR, BUSY
  );

  modport master (
    output IF_REQ, IF_ADDR,
    output D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    output MEM_GNT, MEM_RVALID, MEM_RDATA,
    input  IF_GNT, IF_RVALID, IF_RDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA,
    input  BUS_ERR, BUSY
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between the fetch and load/store requesters.
// One transaction at a time: IDLE grants (round-robin on ties), REQ holds
// the latched request until the memory accepts it, WAIT collects the
// response or gives up after TIMEOUT cycles with a bus-error pulse.
module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              CLK,
  input logic              RST_N,
  core_mem_arbiter_if.slave bus
);

  localparam int   BE_W  = DATA_W / 8;
  localparam int   CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_last_d;     // 1: last granted requester was D
  logic              r_owner_d;    // 1: current transaction belongs to D
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_req;
  logic              r_busy;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;

  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_bus_err;

  logic              w_if_win;
  logic              w_d_win;
  logic              w_rsp;
  logic              w_timeout;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, arbitration and response/timeout decode
  always_comb begin
    w_state_next = r_state;
    w_if_win     = 1'b0;
    w_d_win      = 1'b0;
    w_rsp        = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_next   = r_cnt + CNT_W'(1);
    case (r_state)
      ST_IDLE: begin
        if (bus.IF_REQ && bus.D_REQ) begin
          // Tie: the requester that did not win last time goes first
          if (r_last_d) begin
            w_if_win = 1'b1;
          end else begin
            w_d_win = 1'b1;
          end
        end else if (bus.IF_REQ) begin
          w_if_win = 1'b1;
        end else if (bus.D_REQ) begin
          w_d_win = 1'b1;
        end else begin
          w_if_win = 1'b0;
          w_d_win  = 1'b0;
        end
        if (w_if_win || w_d_win) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        // No limit here: a stalled memory simply keeps the request pending
        if (bus.MEM_GNT) begin
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A response in the same cycle as the timeout takes priority.
        // The timeout fires in the TIMEOUT-th WAIT cycle.
        if (bus.MEM_RVALID) begin
          w_rsp        = 1'b1;
          w_state_next = ST_IDLE;
        end else if (TO_EN && (w_cnt_next == CNT_W'(TIMEOUT))) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the winning request fields and remember the winner
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
      r_we      <= 1'b0;
      r_be      <= {BE_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
    end else if (w_if_win) begin
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= bus.IF_ADDR;
      r_we      <= 1'b0;
      r_be      <= {BE_W{1'b1}};
      r_wdata   <= {DATA_W{1'b0}};
    end else if (w_d_win) begin
      r_last_d  <= 1'b1;
      r_owner_d <= 1'b1;
      r_addr    <= bus.D_ADDR;
      r_we      <= bus.D_WE;
      r_be      <= bus.D_BE;
      r_wdata   <= bus.D_WDATA;
    end
  end

  // Registered MEM_REQ and BUSY, derived from the upcoming state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_mem_req <= (w_state_next == ST_REQ);
      r_busy    <= (w_state_next != ST_IDLE);
    end
  end

  // WAIT-cycle counter, cleared when the memory accepts the request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_REQ) && bus.MEM_GNT) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_WAIT) begin
      r_cnt <= w_cnt_next;
    end
  end

  // One-cycle response pulses routed to the owner; data is zero otherwise
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= {DATA_W{1'b0}};
      r_bus_err   <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= {DATA_W{1'b0}};
      r_bus_err   <= 1'b0;
      if (w_rsp) begin
        if (r_owner_d) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= bus.MEM_RDATA;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.MEM_RDATA;
        end
      end else if (w_timeout) begin
        r_bus_err <= 1'b1;
        if (r_owner_d) begin
          r_d_rvalid <= 1'b1;
        end else begin
          r_if_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.IF_GNT    = w_if_win;
  assign bus.D_GNT     = w_d_win;
  assign bus.IF_RVALID = r_if_rvalid;
  assign bus.IF_RDATA  = r_if_rdata;
  assign bus.D_RVALID  = r_d_rvalid;
  assign bus.D_RDATA   = r_d_rdata;
  assign bus.MEM_REQ   = r_mem_req;
  assign bus.MEM_WE    = r_we;
  assign bus.MEM_BE    = r_be;
  assign bus.MEM_ADDR  = r_addr;
  assign bus.MEM_WDATA = r_wdata;
  assign bus.BUS_ERR   = r_bus_err;
  assign bus.BUSY      = r_busy;

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester and the load/store requester of the multi-cycle RV32I core.
- Accepts one transaction at a time and drives the memory-side req/gnt/rvalid handshake.
- Routes the response back to the owning requester.
- Flags a bus error when the memory does not respond within a bounded time.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, max WAIT-state cycles before bus error; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IF_REQ  in  1  fetch request
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted (1-cycle pulse)
- IF_RVALID  out  1  fetch data valid (1-cycle pulse)
- IF_RDATA  out  DATA_W  fetched instruction
- D_REQ  in  1  data request
- D_WE  in  1  1 = store, 0 = load
- D_BE  in  DATA_W/8  store byte enables
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  data request accepted (1-cycle pulse)
- D_RVALID  out  1  load data / store ack valid (1-cycle pulse)
- D_RDATA  out  DATA_W  load data
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write
- MEM_BE  out  DATA_W/8  memory byte enables
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_GNT  in  1  memory accepted request
- MEM_RVALID  in  1  memory response valid
- MEM_RDATA  in  DATA_W  memory read data
- BUS_ERR  out  1  timeout pulse
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE; last_owner = IF; timeout counter = 0.
  - All outputs 0, including MEM_*, *_RDATA, BUS_ERR and BUSY.
  - An in-flight transaction is abandoned. A MEM_RVALID arriving after reset is ignored, because it arrives in IDLE.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If exactly one requester asserts REQ, that requester wins.
  - If both assert REQ, the winner is the one that is not last_owner (round-robin). After reset, D therefore wins the first tie.
  - Winner's GNT is asserted combinationally in the same cycle.
  - On the clock edge: latch owner, addr, we, be, wdata; last_owner <= winner; next state REQ.
  - For IF transactions MEM_WE = 0, MEM_BE = all-ones, MEM_WDATA = 0.
  - A requester may drop REQ or change its inputs after GNT without effect.
- REQ:
  - MEM_REQ = 1 with the latched fields held stable.
  - MEM_GNT = 1 -> WAIT; counter cleared.
  - MEM_GNT = 0 -> stay in REQ with no limit; the timeout does not apply here.
- WAIT:
  - MEM_REQ = 0; the counter increments each cycle.
  - MEM_RVALID = 1 -> next cycle, the owner's RVALID = 1 and owner RDATA = registered MEM_RDATA (stores also get RVALID as the ack); state -> IDLE.
  - Counter reaches TIMEOUT (TIMEOUT != 0) without MEM_RVALID -> next cycle BUS_ERR = 1, owner RVALID = 1, owner RDATA = 0; state -> IDLE.
  - MEM_RVALID in the same cycle the timeout fires: the response wins and BUS_ERR stays 0.
- Response cycle:
  - State is already IDLE in the cycle RVALID is pulsed, so a new request can be granted in that cycle (back-to-back).
  - The non-owner's RVALID and RDATA stay 0.
- Latency: GNT at cycle t; MEM_REQ at t+1; with MEM_GNT at t+1 and MEM_RVALID at t+2, the requester's RVALID comes at t+3.
- MEM_RVALID sampled in IDLE or REQ is ignored; memory must respond at least 1 cycle after MEM_GNT.
- At most one outstanding transaction at any time.

Test Plan:
- Single fetch: IF_REQ, IF_ADDR=0x0000_0100; memory GNT immediately, RVALID next cycle with 0x0000_0013 -> IF_GNT at t, MEM_REQ/MEM_ADDR=0x100 at t+1, IF_RVALID=1, IF_RDATA=0x13 at t+3; D_RVALID stays 0.
- Simultaneous requests after reset: IF_REQ and D_REQ high and held -> grants in order D, IF, D, IF; no requester granted twice in a row while the other waits.
- Store: D_WE=1, D_BE=4'b0011, D_ADDR=0x2000, D_WDATA=0xDEAD_BEEF -> MEM_WE=1, MEM_BE=0011, MEM_ADDR=0x2000, MEM_WDATA=0xDEADBEEF; D_RVALID pulses 1 cycle after MEM_RVALID.
- Memory stall: MEM_GNT held low 10 cycles -> MEM_REQ and all MEM_* stable for 11 cycles, BUSY=1, no BUS_ERR.
- Timeout with TIMEOUT=4: MEM_GNT given, MEM_RVALID never asserted -> BUS_ERR=1 for exactly 1 cycle with owner RVALID=1 and RDATA=0; next request is granted normally.
- Reset mid-WAIT: RST_N low during WAIT, then MEM_RVALID arrives after release -> all outputs 0 while reset is low; stale response produces no RVALID; next IF_REQ is handled normally.
